// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_pkg
// Brief    : RV32I opcode/funct3 encodings and immediate-format enum shared
//            by the decode stage and its immediate generator.
// Revision : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_JALR = 3'b000;
    localparam logic [2:0] F3_LB   = 3'b000;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_LHU  = 3'b101;
    localparam logic [2:0] F3_SB   = 3'b000;
    localparam logic [2:0] F3_SH   = 3'b001;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    // Opcodes without a funct3 sub-decode are always legal here.
    function automatic logic f_funct3_legal(input logic [6:0] opcode, input logic [2:0] f3);
        case (opcode)
            LOAD:    return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
            STORE:   return f3 inside {F3_SB, F3_SH, F3_SW};
            BRANCH:  return f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU};
            JALR:    return f3 == F3_JALR;
            default: return 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_imm_gen.sv
`default_nettype none
// ============================================================================
// Module   : rv_imm_gen
// Brief    : Combinational RV32I immediate extraction, sign-extended to XLEN.
// Revision : 1.0 - initial release
// ============================================================================
module rv_imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     i_ins,
    input  imm_fmt_e        i_fmt,
    output logic [XLEN-1:0] o_imm
);

    logic [31:0] w_imm32;

    always_comb begin
        w_imm32 = '0;
        case (i_fmt)
            IMM_I:   w_imm32 = {{20{i_ins[31]}}, i_ins[31:20]};
            IMM_S:   w_imm32 = {{20{i_ins[31]}}, i_ins[31:25], i_ins[11:7]};
            IMM_B:   w_imm32 = {{19{i_ins[31]}}, i_ins[31], i_ins[7], i_ins[30:25], i_ins[11:8], 1'b0};
            IMM_U:   w_imm32 = {i_ins[31:12], 12'b0};
            IMM_J:   w_imm32 = {{11{i_ins[31]}}, i_ins[31], i_ins[19:12], i_ins[20], i_ins[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign o_imm = XLEN'($signed(w_imm32));

endmodule
`default_nettype wire

// File: rtl/rv_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : rv_decode_stage
// Brief    : RV32I decode with operand forwarding, load-use stall and a
//            valid/ready ID/EX output register.
// Revision : 1.0 - initial release
// ============================================================================
module rv_decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_ins,
    input  logic [XLEN-1:0]   in_addr,
    input  logic              flush,
    output logic [REG_AW-1:0] rs1_addr_o,
    output logic [REG_AW-1:0] rs2_addr_o,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  logic              ex_wb_en,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [XLEN-1:0]   ex_result,
    input  logic              mem_wb_en,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_ins,
    output logic [XLEN-1:0]   out_addr,
    output logic [XLEN-1:0]   out_src1,
    output logic [XLEN-1:0]   out_src2,
    output logic [XLEN-1:0]   out_imm,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_wb_en,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    output logic              out_branch,
    output logic              out_jump,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic [6:0]        w_opcode;
    imm_fmt_e          w_fmt;
    logic              w_use1, w_use2, w_wb, w_mrd, w_mwr, w_br, w_jmp, w_ill;
    logic              w_s1_pc, w_s1_zero, w_s2_imm;
    logic [XLEN-1:0]   w_imm;
    logic [REG_AW-1:0] w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0]   w_rf1, w_rf2, w_op1, w_op2, w_src1, w_src2;
    logic              w_ex_ok, w_mem_ok, w_ex_hit1, w_ex_hit2, w_mem_hit1, w_mem_hit2;
    logic              w_hz_raw, w_hz, w_free, w_capture;

    logic              r_valid;
    logic [XLEN-1:0]   r_ins, r_addr, r_src1, r_src2, r_imm;
    logic [REG_AW-1:0] r_rd;
    logic              r_wb, r_mrd, r_mwr, r_br, r_jmp, r_ill;
    logic [CNT_W-1:0]  r_stall_cnt;

    assign w_opcode = in_ins[6:0];

    always_comb begin
        w_fmt     = IMM_NONE;
        w_use1    = 1'b0;
        w_use2    = 1'b0;
        w_wb      = 1'b0;
        w_mrd     = 1'b0;
        w_mwr     = 1'b0;
        w_br      = 1'b0;
        w_jmp     = 1'b0;
        w_ill     = !f_funct3_legal(w_opcode, in_ins[14:12]);
        w_s1_pc   = 1'b0;
        w_s1_zero = 1'b0;
        w_s2_imm  = 1'b0;
        case (w_opcode)
            OP:     begin w_use1 = 1'b1; w_use2 = 1'b1; w_wb = 1'b1; end
            OP_IMM: begin w_fmt = IMM_I; w_use1 = 1'b1; w_wb = 1'b1; w_s2_imm = 1'b1; end
            LOAD:   begin w_fmt = IMM_I; w_use1 = 1'b1; w_wb = 1'b1; w_mrd = 1'b1; w_s2_imm = 1'b1; end
            STORE:  begin w_fmt = IMM_S; w_use1 = 1'b1; w_use2 = 1'b1; w_mwr = 1'b1; end
            BRANCH: begin w_fmt = IMM_B; w_use1 = 1'b1; w_use2 = 1'b1; w_br = 1'b1; end
            JAL:    begin w_fmt = IMM_J; w_wb = 1'b1; w_jmp = 1'b1; w_s1_pc = 1'b1; w_s2_imm = 1'b1; end
            JALR:   begin w_fmt = IMM_I; w_use1 = 1'b1; w_wb = 1'b1; w_jmp = 1'b1; w_s2_imm = 1'b1; end
            LUI:    begin w_fmt = IMM_U; w_wb = 1'b1; w_s1_zero = 1'b1; w_s2_imm = 1'b1; end
            AUIPC:  begin w_fmt = IMM_U; w_wb = 1'b1; w_s1_pc = 1'b1; w_s2_imm = 1'b1; end
            default: w_ill = 1'b1;
        endcase
        // Illegal words still travel down the pipe, but must not cause side effects.
        if (w_ill) begin
            w_wb  = 1'b0;
            w_mrd = 1'b0;
            w_mwr = 1'b0;
            w_br  = 1'b0;
            w_jmp = 1'b0;
        end
    end

    rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_ins (in_ins[31:7]),
        .i_fmt (w_fmt),
        .o_imm (w_imm)
    );

    assign w_rs1      = w_use1 ? REG_AW'(in_ins[19:15]) : '0;
    assign w_rs2      = w_use2 ? REG_AW'(in_ins[24:20]) : '0;
    assign w_rd       = w_wb   ? REG_AW'(in_ins[11:7])  : '0;
    assign rs1_addr_o = w_rs1;
    assign rs2_addr_o = w_rs2;

    // A nonzero producer rd can only match a nonzero (hence used) source.
    assign w_ex_ok    = ex_wb_en  && (ex_rd  != '0);
    assign w_mem_ok   = mem_wb_en && (mem_rd != '0);
    assign w_ex_hit1  = w_ex_ok  && (ex_rd  == w_rs1);
    assign w_ex_hit2  = w_ex_ok  && (ex_rd  == w_rs2);
    assign w_mem_hit1 = w_mem_ok && (mem_rd == w_rs1);
    assign w_mem_hit2 = w_mem_ok && (mem_rd == w_rs2);
    assign w_rf1      = (w_rs1 == '0) ? '0 : rs1_data_i;
    assign w_rf2      = (w_rs2 == '0) ? '0 : rs2_data_i;

    generate
        if (FWD_EN != 0) begin : g_fwd
            assign w_op1    = (w_ex_hit1 && !ex_is_load) ? ex_result : w_mem_hit1 ? mem_result : w_rf1;
            assign w_op2    = (w_ex_hit2 && !ex_is_load) ? ex_result : w_mem_hit2 ? mem_result : w_rf2;
            assign w_hz_raw = ex_is_load && (w_ex_hit1 || w_ex_hit2);
        end else begin : g_no_fwd
            assign w_op1    = w_rf1;
            assign w_op2    = w_rf2;
            assign w_hz_raw = w_ex_hit1 || w_ex_hit2 || w_mem_hit1 || w_mem_hit2;
        end
    endgenerate

    assign w_src1    = w_s1_pc ? in_addr : (w_s1_zero ? '0 : w_op1);
    assign w_src2    = w_s2_imm ? w_imm : w_op2;

    assign w_hz      = in_valid && w_hz_raw;
    assign w_free    = !r_valid || out_ready;
    assign in_ready  = flush || (!w_hz && w_free);
    assign w_capture = in_valid && !w_hz && w_free && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_ins       <= '0;
            r_addr      <= '0;
            r_src1      <= '0;
            r_src2      <= '0;
            r_imm       <= '0;
            r_rd        <= '0;
            r_wb        <= 1'b0;
            r_mrd       <= 1'b0;
            r_mwr       <= 1'b0;
            r_br        <= 1'b0;
            r_jmp       <= 1'b0;
            r_ill       <= 1'b0;
            r_stall_cnt <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_free) begin
            r_valid <= w_capture;
            if (w_capture) begin
                r_ins  <= in_ins;
                r_addr <= in_addr;
                r_src1 <= w_src1;
                r_src2 <= w_src2;
                r_imm  <= w_imm;
                r_rd   <= w_rd;
                r_wb   <= w_wb;
                r_mrd  <= w_mrd;
                r_mwr  <= w_mwr;
                r_br   <= w_br;
                r_jmp  <= w_jmp;
                r_ill  <= w_ill;
            end else if (w_hz && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign out_valid   = r_valid;
    assign out_ins     = r_ins;
    assign out_addr    = r_addr;
    assign out_src1    = r_src1;
    assign out_src2    = r_src2;
    assign out_imm     = r_imm;
    assign out_rd      = r_rd;
    assign out_wb_en   = r_wb;
    assign out_mem_rd  = r_mrd;
    assign out_mem_wr  = r_mwr;
    assign out_branch  = r_br;
    assign out_jump    = r_jmp;
    assign out_illegal = r_ill;
    assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Parametrised successor to the combinational RV32I decode unit; folds the ID/EX pipeline register into the block.
- Decodes I/R/B/L/S/JAL/JALR/LUI/AUIPC and forwards operands from EX and MEM.
- Detects load-use hazards and handshakes upstream (IF/ID) and downstream (EX) with valid/ready.
- Provides registered, stall-stable outputs to EX plus a saturating stall counter.

Parameters:
- XLEN, 32, datapath and instruction width.
- REG_AW, 5, register-file address width.
- FWD_EN, 1, 1 = EX/MEM forwarding enabled; 0 = register-file data only, and hazards stall on any EX/MEM match.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  IF/ID holds an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_ins  in  XLEN  instruction word.
- in_addr  in  XLEN  instruction PC.
- flush  in  1  branch/jump redirect from EX.
- rs1_addr_o / rs2_addr_o  out  REG_AW  register-file read addresses (combinational).
- rs1_data_i / rs2_data_i  in  XLEN  register-file read data.
- ex_wb_en, ex_is_load  in  1  EX writes back / EX is a load.
- ex_rd  in  REG_AW  EX destination register.
- ex_result  in  XLEN  EX result.
- mem_wb_en  in  1  MEM writes back.
- mem_rd  in  REG_AW  MEM destination register.
- mem_result  in  XLEN  MEM result.
- out_valid  out  1  EX-side payload valid.
- out_ready  in  1  EX accepts the payload.
- out_ins, out_addr  out  XLEN  instruction word and PC.
- out_src1, out_src2  out  XLEN  operands.
- out_imm  out  XLEN  sign-extended immediate of the decoded format.
- out_rd  out  REG_AW  destination register (0 when no writeback).
- out_wb_en, out_mem_rd, out_mem_wr, out_branch, out_jump, out_illegal  out  1  control flags.
- stall_cnt_o  out  CNT_W  load-use stall cycles, saturating.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0; all out_* registers 0; stall_cnt_o=0. Reset mid-stall drops the held payload.
- rs*_addr_o = ins[19:15] / ins[24:20] when the format uses the field, else 0. The read is combinational, same cycle.
- Operand select, priority order: EX match (ex_wb_en, ex_rd!=0, ex_rd==rs, !ex_is_load) > MEM match (mem_wb_en, mem_rd!=0) > register file. x0 is never forwarded and always reads 0.
- Load-use hazard: ex_is_load & ex_wb_en & ex_rd!=0 & ex_rd equals a used rs. Result: hz=1.
- With FWD_EN=0, hz is also raised on any EX or MEM match.
- in_ready = flush | (!hz & (!out_valid | out_ready)).
- Capture condition: in_valid & in_ready & !flush. Latency is 1 cycle; out_valid=1 on the following cycle.
- While out_valid & !out_ready, every out_* signal is held bit-stable.
- On hz with output free: a bubble is inserted (out_valid=0 next cycle) and stall_cnt_o increments, saturating at all-ones.
- flush: out_valid=0 next cycle and any presented input is discarded (acknowledged via in_ready=1, not captured). Flush wins over capture, hazard and a held payload.
- Immediates:
  - I: ins[31:20]
  - S: {ins[31:25], ins[11:7]}
  - B: {ins[31], ins[7], ins[30:25], ins[11:8], 0}
  - J: {ins[31], ins[19:12], ins[20], ins[30:21], 0}
  - U: {ins[31:12], 12'b0}
  - All are sign-extended to XLEN.
- src2 per type:
  - OP-IMM, LOAD, JALR: imm.
  - R, B, S: rs2 value.
  - LUI/AUIPC: src1 = 0 / in_addr, src2 = imm.
  - JAL: src1 = in_addr.
- Flags:
  - wb_en: R, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC.
  - mem_rd: LOAD. mem_wr: STORE.
  - branch: B. jump: JAL/JALR.
- Illegal: unknown opcode, JALR funct3!=000, LOAD funct3 in {011,110,111}, STORE funct3>010, B funct3 in {010,011}.
  - Illegal instructions are still passed with out_illegal=1; all other flags 0 and out_rd=0.
- out_rd is forced to 0 whenever wb_en=0.

Decomposition:
- Package rv_pkg holds:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC).
  - funct3 encodings.
  - imm-format enum (IMM_I/S/B/U/J/NONE).
- Sub-module rv_imm_gen: combinational, ins plus format in, XLEN immediate out.
- Hazard/forward logic and the output register stay in the top block.

Test Plan:
- ADDI x1,x0,-5 (0xFFB00093) with out_ready=1 → next cycle out_valid=1, out_src2=0xFFFFFFFB, out_rd=1, out_wb_en=1.
- Two R-type ADDs with the second stalled by out_ready=0 for 3 cycles → outputs hold the first ADD unchanged, in_ready=0. On release, the second is captured the following cycle.
- LW x5 in EX (ex_is_load=1, ex_rd=5) with ADD x6,x5,x7 presented → in_ready=0 for one cycle, bubble out_valid=0, stall_cnt_o 0→1.
- ex_rd=3/ex_result=0xAA and mem_rd=3/mem_result=0xBB with rs1=3 → out_src1=0xAA. With ex_wb_en=0 → 0xBB. With rs1=0 → 0.
- flush asserted while out_valid=1 and out_ready=0, input valid → next cycle out_valid=0, input not captured.
- Opcode 0x7F and JALR with funct3=010 → out_illegal=1, out_wb_en=0, out_rd=0.
